sd_fifo_arbiter: RTL and testbench

N-port, round-robin arbiter owning the single byte-wide data FIFO interface of the SD controller. It replaces the static two-way SPI/FPGA select with runtime arbitration. The SPI link state machine, the audio streaming engine and future masters each request the SD FIFO and get exclusive, burst-bounded access. It sits between the masters and sdc_controller's rd_en_i/rd_dat_o/wr_en_i/wr_dat_i.

---
 rtl/sd_fifo_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_sd_fifo_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_fifo_arbiter.sv
// sd_fifo_arbiter
// Round-robin arbiter that shares the SD controller's single byte-wide FIFO
// port between N masters. Each owner gets exclusive access until it drops its
// request, fills a full SD block (BURST_LEN beats) or goes quiet for
// IDLE_TIMEOUT cycles. A force mode pins the grant to one port for debug or
// streaming. After every release there is at least one cycle with no owner.
// Strobes from ports without a grant are never forwarded. Instead, they are
// reported on viol.

module sd_fifo_arbiter #(
  parameter int N_PORTS      = 2,
  parameter int DATA_W       = 8,
  parameter int BURST_LEN    = 512,
  parameter int IDLE_TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_PORTS-1:0]         req,
  output logic [N_PORTS-1:0]         gnt,
  input  logic [N_PORTS-1:0]         rd_en,
  input  logic [N_PORTS-1:0]         wr_en,
  input  logic [N_PORTS*DATA_W-1:0]  wr_dat,
  output logic [N_PORTS*DATA_W-1:0]  rd_dat,
  output logic                       fifo_rd_en,
  input  logic [DATA_W-1:0]          fifo_rd_dat,
  output logic                       fifo_wr_en,
  output logic [DATA_W-1:0]          fifo_wr_dat,
  input  logic                       force_en,
  input  logic [$clog2(N_PORTS)-1:0] force_sel,
  output logic                       burst_done,
  output logic                       viol
);

  localparam int SEL_W  = $clog2(N_PORTS);
  localparam int BEAT_W = $clog2(BURST_LEN + 1);
  localparam int IDLE_W = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;

  localparam logic [BEAT_W-1:0] BEAT_MAX  = BEAT_W'(BURST_LEN);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(IDLE_TIMEOUT);
  localparam logic [IDLE_W-1:0] IDLE_SAT  = '1;
  localparam logic [SEL_W-1:0]  LAST_PORT = SEL_W'(N_PORTS - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [N_PORTS-1:0]   gnt_q, gnt_d;
  logic [SEL_W-1:0]     owner_q, owner_d;
  logic [SEL_W-1:0]     ptr_q, ptr_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic [IDLE_W-1:0]    idle_q, idle_d;
  logic                 forced_q, forced_d;
  logic                 burst_done_q, burst_done_d;
  logic                 viol_q, viol_d;

  logic                 rr_found;
  logic [SEL_W-1:0]     rr_idx;
  logic [SEL_W-1:0]     rr_cand;
  logic                 force_ok;
  logic                 beat;
  logic [BEAT_W-1:0]    beat_inc;
  logic [IDLE_W-1:0]    idle_inc;
  logic                 burst_hit;
  logic                 idle_hit;
  logic                 drop;

  assign gnt        = gnt_q;
  assign burst_done = burst_done_q;
  assign viol       = viol_q;

  // Zero-latency datapath: only the granted port reaches the FIFO.
  always_comb begin
    // NOTE: every output of a combinational block gets a value before any
    // conditional code. If a path leaves one unassigned, synthesis infers a latch.
    fifo_rd_en  = |(rd_en & gnt_q);
    fifo_wr_en  = |(wr_en & gnt_q);
    fifo_wr_dat = '0;
    rd_dat      = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (gnt_q[i]) begin
        fifo_wr_dat                  = fifo_wr_dat | wr_dat[i*DATA_W +: DATA_W];
        rd_dat[i*DATA_W +: DATA_W]   = fifo_rd_dat;
      end
    end
  end

  // Round-robin pick: first requesting port at or after the pointer, wrapping.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = ptr_q;
    rr_cand  = ptr_q;
    for (int k = 0; k < N_PORTS; k++) begin
      rr_cand = SEL_W'((int'(ptr_q) + k) % N_PORTS);
      if (!rr_found && req[rr_cand]) begin
        rr_found = 1'b1;
        rr_idx   = rr_cand;
      end
    end
  end

  // Beat and idle bookkeeping for the current owner. Both counters saturate.
  always_comb begin
    force_ok  = (int'(force_sel) < N_PORTS);
    beat      = fifo_rd_en | fifo_wr_en;
    beat_inc  = (beat && (beat_q != BEAT_MAX)) ? beat_q + 1'b1 : beat_q;
    burst_hit = beat && (beat_inc == BEAT_MAX);
    idle_inc  = beat ? '0 : ((idle_q == IDLE_SAT) ? idle_q : idle_q + 1'b1);
    idle_hit  = (IDLE_TIMEOUT != 0) && !beat && (idle_inc == IDLE_MAX);
  end

  // Next-state logic: grant selection, release conditions, pulse outputs.
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    owner_d      = owner_q;
    ptr_d        = ptr_q;
    beat_d       = beat_q;
    idle_d       = idle_q;
    forced_d     = forced_q;
    burst_done_d = 1'b0;
    drop         = 1'b0;
    // Registered one cycle later. A strobe from any port that does not hold
    // the grant is flagged, including strobes while nobody owns the FIFO.
    viol_d       = |((rd_en | wr_en) & ~gnt_q);

    unique case (state_q)
      ST_IDLE: begin
        beat_d = '0;
        idle_d = '0;
        if (force_en) begin
          // Forcing bypasses arbitration entirely. An out-of-range select
          // leaves the FIFO unowned.
          if (force_ok) begin
            state_d          = ST_GRANT;
            gnt_d            = '0;
            gnt_d[force_sel] = 1'b1;
            owner_d          = force_sel;
            forced_d         = 1'b1;
          end
        end else if (rr_found) begin
          state_d       = ST_GRANT;
          gnt_d         = '0;
          gnt_d[rr_idx] = 1'b1;
          owner_d       = rr_idx;
          forced_d      = 1'b0;
        end
      end

      ST_GRANT: begin
        if (force_en && (!forced_q || (force_sel != owner_q))) begin
          // A new or changed force target first releases the current owner.
          drop = 1'b1;
        end else if (force_en) begin
          // A forced grant never ends. Each completed block restarts the count.
          beat_d       = burst_hit ? '0 : beat_inc;
          idle_d       = idle_inc;
          burst_done_d = burst_hit;
        end else if (!req[owner_q]) begin
          drop = 1'b1;
        end else if (burst_hit) begin
          drop         = 1'b1;
          burst_done_d = 1'b1;
        end else if (idle_hit) begin
          drop = 1'b1;
        end else begin
          beat_d = beat_inc;
          idle_d = idle_inc;
        end

        if (drop) begin
          state_d = ST_RELEASE;
          gnt_d   = '0;
          ptr_d   = (owner_q == LAST_PORT) ? '0 : owner_q + 1'b1;
        end
      end

      ST_RELEASE: begin
        // Dead cycle between owners. The pointer has already advanced.
        state_d  = ST_IDLE;
        beat_d   = '0;
        idle_d   = '0;
        forced_d = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State and counter registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      gnt_q        <= '0;
      owner_q      <= '0;
      ptr_q        <= '0;
      beat_q       <= '0;
      idle_q       <= '0;
      forced_q     <= 1'b0;
      burst_done_q <= 1'b0;
      viol_q       <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every
      // register samples the values from before the clock edge.
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      owner_q      <= owner_d;
      ptr_q        <= ptr_d;
      beat_q       <= beat_d;
      idle_q       <= idle_d;
      forced_q     <= forced_d;
      burst_done_q <= burst_done_d;
      viol_q       <= viol_d;
    end
  end

endmodule

// File: tb/tb_sd_fifo_arbiter.sv
// Self-checking bench for sd_fifo_arbiter (3 ports, 8-bit data, 512-beat
// bursts, 255-cycle idle timeout). The bench drives inputs on the falling
// edge and samples outputs 1 time unit later. A table of per-cycle vectors
// covers the datapath and viol. Directed sequences cover the multi-cycle
// corners. A randomized phase is compared against an integer-level model.

module tb_sd_fifo_arbiter;

  localparam int N  = 3;
  localparam int DW = 8;
  localparam int BL = 512;
  localparam int TO = 255;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     req;
  logic [N-1:0]     gnt;
  logic [N-1:0]     rd_en;
  logic [N-1:0]     wr_en;
  logic [N*DW-1:0]  wr_dat;
  logic [N*DW-1:0]  rd_dat;
  logic             fifo_rd_en;
  logic [DW-1:0]    fifo_rd_dat;
  logic             fifo_wr_en;
  logic [DW-1:0]    fifo_wr_dat;
  logic             force_en;
  logic [1:0]       force_sel;
  logic             burst_done;
  logic             viol;

  sd_fifo_arbiter #(
    .N_PORTS(N), .DATA_W(DW), .BURST_LEN(BL), .IDLE_TIMEOUT(TO)
  ) u_dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .rd_en(rd_en), .wr_en(wr_en),
    .wr_dat(wr_dat), .rd_dat(rd_dat), .fifo_rd_en(fifo_rd_en),
    .fifo_rd_dat(fifo_rd_dat), .fifo_wr_en(fifo_wr_en),
    .fifo_wr_dat(fifo_wr_dat), .force_en(force_en), .force_sel(force_sel),
    .burst_done(burst_done), .viol(viol)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int gnt_idx(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return -1;
  endfunction

  task automatic clear_inputs();
    req = '0; rd_en = '0; wr_en = '0; wr_dat = '0; fifo_rd_dat = '0;
    force_en = 1'b0; force_sel = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); @(negedge clk); rst = 1'b0;
  endtask

  // Count the negedges on which gnt is zero. The loop is bounded.
  task automatic count_dead(output int zeros);
    zeros = 0;
    while (gnt == '0 && zeros < 50) begin
      zeros++;
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [N-1:0]    req;
    logic [N-1:0]    rd_en;
    logic [N-1:0]    wr_en;
    logic [N*DW-1:0] wr_dat;
    logic [DW-1:0]   frd;
    logic [N-1:0]    e_gnt;
    logic            e_rd;
    logic            e_wr;
    logic [DW-1:0]   e_wdat;
    logic [N*DW-1:0] e_rdat;
    logic            e_viol;
  } vec_t;

  vec_t vecs[9];

  int n, zeros, pulses, bad, o, first_zero_done;
  int exp_order[4];

  // integer-level reference model state for the random phase
  int m_owner, m_cool, m_ptr, m_beats, m_idle;
  bit m_done, m_viol, m_beat, m_rel;
  logic [38:0] exp_vec;
  logic [N-1:0] e_gnt;
  logic [N*DW-1:0] e_rdat;
  logic [DW-1:0] e_wdat;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---------------- reset state (strobes active during reset) ----------
    clear_inputs();
    rd_en = 3'b111; wr_en = 3'b111; wr_dat = 24'hFFFFFF; fifo_rd_dat = 8'hEE;
    @(negedge clk); #1;
    check("rst_gnt", gnt, 3'b000);
    check("rst_burst_done", burst_done, 1'b0);
    check("rst_viol", viol, 1'b0);
    check("rst_fifo_rd_en", fifo_rd_en, 1'b0);
    check("rst_fifo_wr_en", fifo_wr_en, 1'b0);
    check("rst_fifo_wr_dat", fifo_wr_dat, 8'h00);
    check("rst_rd_dat", rd_dat, 24'h0);
    clear_inputs();
    @(negedge clk); rst = 1'b0;

    // ---------------- table-driven datapath / violation sequence ---------
    vecs[0] = '{3'b001, 3'b000, 3'b000, 24'h000000, 8'h00, 3'b000, 1'b0, 1'b0, 8'h00, 24'h000000, 1'b0};
    vecs[1] = '{3'b001, 3'b000, 3'b001, 24'h00003C, 8'h00, 3'b001, 1'b0, 1'b1, 8'h3C, 24'h000000, 1'b0};
    vecs[2] = '{3'b001, 3'b000, 3'b011, 24'h00A53C, 8'h00, 3'b001, 1'b0, 1'b1, 8'h3C, 24'h000000, 1'b0};
    vecs[3] = '{3'b001, 3'b000, 3'b001, 24'h00A53C, 8'h00, 3'b001, 1'b0, 1'b1, 8'h3C, 24'h000000, 1'b1};
    vecs[4] = '{3'b001, 3'b001, 3'b000, 24'h00003C, 8'h5A, 3'b001, 1'b1, 1'b0, 8'h3C, 24'h00005A, 1'b0};
    vecs[5] = '{3'b000, 3'b000, 3'b000, 24'h000000, 8'h77, 3'b001, 1'b0, 1'b0, 8'h00, 24'h000077, 1'b0};
    vecs[6] = '{3'b000, 3'b000, 3'b000, 24'h000000, 8'h77, 3'b000, 1'b0, 1'b0, 8'h00, 24'h000000, 1'b0};
    vecs[7] = '{3'b010, 3'b010, 3'b000, 24'h000000, 8'h11, 3'b000, 1'b0, 1'b0, 8'h00, 24'h000000, 1'b0};
    vecs[8] = '{3'b010, 3'b000, 3'b000, 24'h000000, 8'h22, 3'b010, 1'b0, 1'b0, 8'h00, 24'h002200, 1'b1};
    for (int i = 0; i < 9; i++) begin
      req = vecs[i].req; rd_en = vecs[i].rd_en; wr_en = vecs[i].wr_en;
      wr_dat = vecs[i].wr_dat; fifo_rd_dat = vecs[i].frd;
      #1;
      check($sformatf("vec%0d_gnt", i), gnt, vecs[i].e_gnt);
      check($sformatf("vec%0d_fifo_rd_en", i), fifo_rd_en, vecs[i].e_rd);
      check($sformatf("vec%0d_fifo_wr_en", i), fifo_wr_en, vecs[i].e_wr);
      check($sformatf("vec%0d_fifo_wr_dat", i), fifo_wr_dat, vecs[i].e_wdat);
      check($sformatf("vec%0d_rd_dat", i), rd_dat, vecs[i].e_rdat);
      check($sformatf("vec%0d_viol", i), viol, vecs[i].e_viol);
      @(negedge clk);
    end

    // ---------------- reset in the middle of a grant ---------------------
    do_reset();
    req = 3'b010;
    @(negedge clk);
    check("mid_gnt", gnt, 3'b010);
    rd_en = 3'b010; n = 0;
    for (int i = 0; i < 37; i++) begin
      #1; if (fifo_rd_en) n++;
      @(negedge clk);
    end
    check("mid_beats", n, 37);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_gnt", gnt, 3'b000);
    check("mid_rst_fifo_rd_en", fifo_rd_en, 1'b0);
    rd_en = '0; req = '0;
    @(negedge clk); rst = 1'b0; req = 3'b011;
    @(negedge clk);
    check("post_rst_first_owner", gnt, 3'b001);

    // ---------------- round robin with all ports requesting --------------
    do_reset();
    exp_order = '{0, 1, 2, 0};
    req = 3'b111;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      count_dead(zeros);
      if (k > 0) check($sformatf("rr%0d_gap", k), zeros, 2);
      check($sformatf("rr%0d_owner", k), gnt_idx(gnt), exp_order[k]);
      o = gnt_idx(gnt);
      if (o < 0) o = 0;
      rd_en = gnt; n = 0;
      for (int b = 0; b < 4; b++) begin
        #1; if (fifo_rd_en) n++;
        @(negedge clk);
      end
      check($sformatf("rr%0d_beats", k), n, 4);
      rd_en = '0; req[o] = 1'b0;
      @(negedge clk);
      req[o] = 1'b1;
    end

    // ---------------- burst limit ----------------------------------------
    do_reset();
    req = 3'b011;
    @(negedge clk);
    n = 0; pulses = 0; zeros = 0; first_zero_done = 0;
    for (int c = 0; c < 700 && gnt != 3'b010; c++) begin
      rd_en = (gnt == 3'b001) ? 3'b001 : 3'b000;
      #1;
      if (fifo_rd_en) n++;
      if (burst_done) pulses++;
      if (gnt == '0) begin
        if (zeros == 0) first_zero_done = int'(burst_done);
        zeros++;
      end
      @(negedge clk);
    end
    rd_en = '0;
    check("burst_beats", n, BL);
    check("burst_done_pulses", pulses, 1);
    check("burst_done_on_release", first_zero_done, 1);
    check("burst_gap", zeros, 2);
    check("burst_next_owner", gnt, 3'b010);

    // ---------------- idle timeout, pointer wraps to port 0 --------------
    do_reset();
    req = 3'b010;
    @(negedge clk);
    check("idle_first_owner", gnt, 3'b010);
    req = 3'b011; n = 0;
    while (gnt == 3'b010 && n < 400) begin
      n++;
      @(negedge clk);
    end
    check("idle_grant_cycles", n, TO);
    count_dead(zeros);
    check("idle_gap", zeros, 2);
    check("idle_next_owner", gnt, 3'b001);

    // ---------------- force mode -----------------------------------------
    do_reset();
    force_en = 1'b1; force_sel = 2'd1;
    @(negedge clk);
    check("force_gnt_latency", gnt, 3'b010);
    rd_en = 3'b010; bad = 0; pulses = 0;
    for (int c = 0; c < 1100; c++) begin
      #1;
      if (gnt != 3'b010) bad++;
      if (burst_done) pulses++;
      @(negedge clk);
    end
    check("force_gnt_held", bad, 0);
    check("force_burst_done_pulses", pulses, 2);
    rd_en = '0; force_sel = 2'd0;
    @(negedge clk);
    count_dead(zeros);
    check("force_change_gap", zeros, 2);
    check("force_change_owner", gnt, 3'b001);

    // ---------------- randomized vs reference model ----------------------
    do_reset();
    m_owner = -1; m_cool = 0; m_ptr = 0; m_beats = 0; m_idle = 0;
    m_done = 1'b0; m_viol = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(15) == 0) req[i] = ~req[i];
      rd_en = '0; wr_en = '0;
      if (m_owner >= 0) begin
        rd_en[m_owner] = 1'($urandom_range(1));
        wr_en[m_owner] = 1'($urandom_range(1));
      end
      if ($urandom_range(63) == 0) wr_en[$urandom_range(N-1)] = 1'b1;
      wr_dat = 24'($urandom);
      fifo_rd_dat = 8'($urandom);
      #1;
      // expected outputs from the model's notion of the current owner
      e_gnt = '0; e_rdat = '0; e_wdat = '0; m_beat = 1'b0;
      if (m_owner >= 0) begin
        e_gnt[m_owner] = 1'b1;
        e_rdat[m_owner*DW +: DW] = fifo_rd_dat;
        e_wdat = wr_dat[m_owner*DW +: DW];
        m_beat = rd_en[m_owner] | wr_en[m_owner];
      end
      exp_vec = {e_gnt, (m_owner >= 0) && rd_en[m_owner], (m_owner >= 0) && wr_en[m_owner],
                 e_wdat, e_rdat, m_done, m_viol};
      check($sformatf("rand_cycle%0d", c),
            {gnt, fifo_rd_en, fifo_wr_en, fifo_wr_dat, rd_dat, burst_done, viol}, exp_vec);
      // advance the model across the coming clock edge
      m_viol = |((rd_en | wr_en) & ~e_gnt);
      m_done = 1'b0;
      m_rel  = 1'b0;
      if (m_owner < 0) begin
        if (m_cool != 0) m_cool = 0;
        else if (req != '0) begin
          for (int k = 0; k < N; k++) begin
            if (m_owner < 0 && req[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
          end
          m_beats = 0; m_idle = 0;
        end
      end else begin
        if (!req[m_owner]) m_rel = 1'b1;
        else if (m_beat) begin
          m_beats++; m_idle = 0;
          if (m_beats == BL) begin m_rel = 1'b1; m_done = 1'b1; end
        end else begin
          m_idle++;
          if (m_idle == TO) m_rel = 1'b1;
        end
        if (m_rel) begin
          m_ptr = (m_owner + 1) % N;
          m_owner = -1;
          m_cool = 1;
        end
      end
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
